// File: rtl/flex_down_timer.sv
// flex_down_timer: loadable down-counting timer with one-shot or periodic auto-reload.
// Define FLEX_DOWN_TIMER_PRESCALE_EN to divide count_enable by prescale_val+1.
module flex_down_timer #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      load,
  input  logic [NUM_CNT_BITS-1:0]   load_val,
  input  logic                      periodic,
  input  logic                      count_enable,
  input  logic [PRESCALE_BITS-1:0]  prescale_val,
  output logic [NUM_CNT_BITS-1:0]   count_out,
  output logic                      busy,
  output logic                      expire_flag,
  output logic                      load_err
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);
  logic                    state;
  logic [NUM_CNT_BITS-1:0] reload_reg;
  logic                    periodic_reg;
  logic                    tick;
  logic                    good_load;
  assign busy      = state == RUN;
  assign good_load = load && load_val != '0;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] pre_cnt;
  assign tick = count_enable && pre_cnt == prescale_val;
  // A tick always returns pre_cnt to zero, which also covers expiry to IDLE.
  always_ff @(posedge clk) begin
    if (!n_rst || clear || good_load)
      pre_cnt <= '0;
    else if (state == RUN && count_enable)
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_val;
  assign tick = count_enable;
`endif
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      count_out    <= '0;
      expire_flag  <= 1'b0;
      load_err     <= 1'b0;
      reload_reg   <= '0;
      periodic_reg <= 1'b0;
    end else begin
      expire_flag <= 1'b0;
      load_err    <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        count_out <= '0;
      end else if (load) begin
        if (good_load) begin
          state        <= RUN;
          count_out    <= load_val;
          reload_reg   <= load_val;
          periodic_reg <= periodic;
        end else begin
          load_err <= 1'b1;
        end
      end else if (state == RUN && tick) begin
        if (count_out == ONE) begin
          expire_flag <= 1'b1;
          count_out   <= periodic_reg ? reload_reg : '0;
          state       <= periodic_reg ? RUN : IDLE;
        end else begin
          count_out <= count_out - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_flex_down_timer.sv
// tb_flex_down_timer: directed and random stimulus against a cycle model of the timer,
// plus literal expectations pinning the model.
module tb_flex_down_timer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       periodic = 1'b0;
  logic       count_enable = 1'b0;
  logic [3:0] prescale_val = 4'd0;
  logic [3:0] count_out;
  logic       busy;
  logic       expire_flag;
  logic       load_err;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  int m_cnt = 0, m_rel = 0, m_pre = 0;
  bit m_run = 0, m_per = 0, m_exp = 0, m_err = 0;

  flex_down_timer #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .periodic(periodic), .count_enable(count_enable), .prescale_val(prescale_val),
    .count_out(count_out), .busy(busy), .expire_flag(expire_flag), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remaining ticks until expiry, decremented once per (prescaled) enabled cycle.
  always @(posedge clk) begin
    bit ticked;
    m_exp = 0;
    m_err = 0;
    if (!n_rst) begin
      m_cnt = 0; m_rel = 0; m_per = 0; m_run = 0; m_pre = 0;
    end else if (clear) begin
      m_cnt = 0; m_run = 0; m_pre = 0;
    end else if (load) begin
      if (load_val == 0) m_err = 1;
      else begin
        m_cnt = int'(load_val); m_rel = m_cnt; m_per = periodic; m_run = 1; m_pre = 0;
      end
    end else if (m_run && count_enable) begin
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
      ticked = (m_pre == int'(prescale_val));
      m_pre = ticked ? 0 : m_pre + 1;
`else
      ticked = 1;
`endif
      if (ticked) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_exp = 1;
          if (m_per) m_cnt = m_rel;
          else m_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_count", int'(count_out), m_cnt);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_expire", int'(expire_flag), int'(m_exp));
      chk("model_load_err", int'(load_err), int'(m_err));
    end
  end

  task automatic drive(input bit r, input bit c, input bit l, input int v, input bit p, input bit e);
    n_rst = r; clear = c; load = l; load_val = 4'(v); periodic = p; count_enable = e;
    @(negedge clk);
  endtask

  task automatic tick_en(input bit e);
    drive(1, 0, 0, 0, 0, e);
  endtask

  initial begin
    int seen;
    drive(0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    chk("reset_count", int'(count_out), 0);
    chk("reset_busy", int'(busy), 0);
    // one-shot load of 3
    drive(1, 0, 1, 3, 0, 1);
    chk("os_load", int'(count_out), 3);
    chk("os_busy", int'(busy), 1);
    tick_en(1); chk("os_2", int'(count_out), 2);
    tick_en(1); chk("os_1", int'(count_out), 1);
    chk("os_no_exp", int'(expire_flag), 0);
    tick_en(1); chk("os_0", int'(count_out), 0);
    chk("os_exp", int'(expire_flag), 1);
    chk("os_busy_drop", int'(busy), 0);
    tick_en(1); chk("os_exp_once", int'(expire_flag), 0);
    chk("os_stay0", int'(count_out), 0);
    // periodic load of 2
    drive(1, 0, 1, 2, 1, 1);
    chk("per_load", int'(count_out), 2);
    tick_en(1); chk("per_1", int'(count_out), 1);
    tick_en(1); chk("per_reload", int'(count_out), 2);
    chk("per_exp", int'(expire_flag), 1);
    chk("per_busy", int'(busy), 1);
    tick_en(1); chk("per_1b", int'(count_out), 1);
    chk("per_noexp", int'(expire_flag), 0);
    // reset mid-run
    drive(1, 0, 1, 5, 0, 0);
    chk("rst_pre", int'(count_out), 5);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_mid_count", int'(count_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    // priority: clear over load over tick
    drive(1, 0, 1, 6, 0, 1);
    tick_en(1); tick_en(1);
    chk("pri_pre", int'(count_out), 4);
    drive(1, 1, 1, 9, 0, 1);
    chk("pri_clear_count", int'(count_out), 0);
    chk("pri_clear_busy", int'(busy), 0);
    chk("pri_clear_noexp", int'(expire_flag), 0);
    drive(1, 0, 1, 9, 0, 1);
    chk("pri_load_nodec", int'(count_out), 9);
    // zero load error keeps state
    drive(1, 0, 1, 0, 1, 0);
    chk("err_pulse", int'(load_err), 1);
    chk("err_count", int'(count_out), 9);
    chk("err_busy", int'(busy), 1);
    tick_en(0); chk("err_once", int'(load_err), 0);
    // enable gaps
    drive(1, 0, 1, 15, 0, 1);
    chk("gap_15", int'(count_out), 15);
    tick_en(1); chk("gap_14", int'(count_out), 14);
    tick_en(0); chk("gap_hold", int'(count_out), 14);
    tick_en(1); chk("gap_13", int'(count_out), 13);
    // max value expires after 15 ticks
    drive(1, 0, 1, 15, 0, 0);
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick_en(1);
      if (expire_flag && seen == 0) seen = i;
    end
    chk("max_expire_tick", seen, 15);
    // load_val 1 periodic: expire every ticked cycle
    drive(1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick_en(1);
      chk("one_per_exp", int'(expire_flag), 1);
      chk("one_per_cnt", int'(count_out), 1);
    end
    // prescaler
    prescale_val = 4'd2;
    drive(1, 0, 1, 2, 0, 0);
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick_en(1);
      if (expire_flag && seen == 0) seen = i;
    end
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    chk("prescale_expire", seen, 6);
`else
    chk("prescale_expire", seen, 2);
`endif
    // random traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      prescale_val = 4'($urandom_range(0, 3));
      drive($urandom_range(0, 60) != 0, $urandom_range(0, 25) == 0, $urandom_range(0, 8) == 0,
            $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    end
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
